// File: rtl/ppu_bus_writer.sv
// ppu_bus_writer: buffers PPU table-write commands from a valid/ready stream
// and replays them onto the PPU memory-mapped write port only while the raster
// is inside the vertical-blanking write window [VB_FIRST, VB_LAST].
//
// Optional feature macro: PPU_WRITER_BUDGET_EN
//   When defined, at most BUDGET bus writes are issued per window; once that
//   count is reached the writer parks in SPENT until the window closes.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready registered)
//   cmd_table/index/data   command payload -> address[9:8], address[7:0], writedata
//   vcount                 raster line number
//   chipselect/write       PPU bus strobes (registered, always equal)
//   address/writedata      PPU bus address and data (registered)
//   level                  FIFO occupancy
//   window                 registered "vcount is inside the write window"
module ppu_bus_writer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned VB_FIRST = 480,
    parameter int unsigned VB_LAST  = 523,
    parameter int unsigned BUDGET   = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_table,
    input  logic [7:0]             cmd_index,
    input  logic [31:0]            cmd_data,
    input  logic [9:0]             vcount,
    output logic                   chipselect,
    output logic                   write,
    output logic [15:0]            address,
    output logic [31:0]            writedata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   window
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [9:0]  VB_FIRST_V = 10'(VB_FIRST);
    localparam logic [9:0]  VB_LAST_V  = 10'(VB_LAST);

    // Reject parameter sets the pointer arithmetic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BUDGET < 1) begin : g_bad_params
        $error("ppu_bus_writer: DEPTH must be a power of two >= 2 and BUDGET >= 1");
    end

    typedef struct packed {
        logic [1:0]  tbl;
        logic [7:0]  index;
        logic [31:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ISSUE = 2'd1
`ifdef PPU_WRITER_BUDGET_EN
        ,
        ST_SPENT = 2'd2
`endif
    } state_t;

    state_t        state;
    state_t        state_next;
    cmd_t          mem [DEPTH];
    cmd_t          head_c;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_c;
    logic          pop_c;
    logic [LW-1:0] level_next_c;
    logic          budget_left_c;

    assign push_c       = cmd_valid & cmd_ready;
    assign head_c       = mem[rd_ptr];
    assign level_next_c = level + LW'(push_c) - LW'(pop_c);

`ifdef PPU_WRITER_BUDGET_EN
    localparam int unsigned CW = $clog2(BUDGET) + 1;

    logic [CW-1:0] frame_cnt;
    logic          window_prev;
    logic          window_rise_c;

    // A rising window restarts the frame count, so a stale count from the
    // previous frame must not hold the FSM in WAIT on the entry cycle.
    assign window_rise_c = window & ~window_prev;
    assign budget_left_c = window_rise_c | (frame_cnt < CW'(BUDGET));

    // Writes issued since the window last opened.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            window_prev <= 1'b0;
        end else begin
            window_prev <= window;
            if (window_rise_c) begin
                frame_cnt <= '0;
            end else if (pop_c) begin
                frame_cnt <= frame_cnt + CW'(1);
            end
        end
    end
`else
    assign budget_left_c = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and pop decision; a pop only happens from ISSUE.
    always_comb begin
        state_next = state;
        pop_c      = 1'b0;
        case (state)
            ST_WAIT: begin
                if (window && level != '0 && budget_left_c) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!window || level == '0) begin
                    state_next = ST_WAIT;
`ifdef PPU_WRITER_BUDGET_EN
                end else if (!budget_left_c) begin
                    state_next = ST_SPENT;
`endif
                end else begin
                    pop_c = 1'b1;
                end
            end
`ifdef PPU_WRITER_BUDGET_EN
            ST_SPENT: begin
                if (!window) begin
                    state_next = ST_WAIT;
                end
            end
`endif
            default: state_next = ST_WAIT;
        endcase
    end

    // FIFO pointers, occupancy, window flag and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            cmd_ready  <= 1'b1;
            window     <= 1'b0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level      <= level_next_c;
            cmd_ready  <= (level_next_c != LW'(DEPTH));
            window     <= (vcount >= VB_FIRST_V) && (vcount <= VB_LAST_V);
            chipselect <= pop_c;
            write      <= pop_c;
            address    <= pop_c ? {6'b0, head_c.tbl, head_c.index} : 16'h0000;
            writedata  <= pop_c ? head_c.data : 32'h0000_0000;
        end
    end

    // Command storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{tbl: cmd_table, index: cmd_index, data: cmd_data};
        end
    end

endmodule

// File: tb/tb_ppu_bus_writer.sv
// Self-checking bench for ppu_bus_writer: directed sequences, a vector table
// for address formatting / issue latency, and a randomized run scored against
// a queue-based reference model.
module tb_ppu_bus_writer;

    localparam int DEPTH     = 16;
    localparam int VB_FIRST  = 480;
    localparam int VB_LAST   = 523;
    localparam int TB_BUDGET = 4;
`ifdef PPU_WRITER_BUDGET_EN
    localparam int EFF_BUDGET = TB_BUDGET;
`else
    localparam int EFF_BUDGET = 1 << 30;
`endif

    typedef struct packed {
        logic [1:0]  tbl;
        logic [7:0]  idx;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        logic [1:0]  tbl;
        logic [7:0]  idx;
        logic [31:0] data;
        logic [15:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [9:0] v;
        logic       exp_win;
    } wvec_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_table;
    logic [7:0]  cmd_index;
    logic [31:0] cmd_data;
    logic [9:0]  vcount;
    logic        chipselect;
    logic        write;
    logic [15:0] address;
    logic [31:0] writedata;
    logic [4:0]  level;
    logic        window;

    int checks = 0;
    int errors = 0;

    cmd_t got[$];
    cmd_t exp[$];
    cmd_t mq[$];
    logic m_win;
    int   m_frame;
    int   m_stall;

    ppu_bus_writer #(
        .DEPTH   (DEPTH),
        .VB_FIRST(VB_FIRST),
        .VB_LAST (VB_LAST),
        .BUDGET  (TB_BUDGET)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_table (cmd_table),
        .cmd_index (cmd_index),
        .cmd_data  (cmd_data),
        .vcount    (vcount),
        .chipselect(chipselect),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .level     (level),
        .window    (window)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic in_range(input logic [9:0] v);
        return (int'(v) >= VB_FIRST) && (int'(v) <= VB_LAST);
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.tbl  = 2'($urandom);
        c.idx  = 8'($urandom);
        c.data = $urandom;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and capture any bus write.
    task automatic tick_obs();
        cmd_t c;
        tick();
        if (chipselect) begin
            check("write_eq_cs", 32'(write), 32'(1));
            check("addr_hi_zero", 32'(address[15:10]), 32'(0));
            c.tbl  = address[9:8];
            c.idx  = address[7:0];
            c.data = writedata;
            got.push_back(c);
        end
    endtask

    task automatic ticks_obs(input int n);
        for (int i = 0; i < n; i++) tick_obs();
    endtask

    task automatic drive_cmd(input cmd_t c);
        cmd_valid = 1'b1;
        cmd_table = c.tbl;
        cmd_index = c.idx;
        cmd_data  = c.data;
    endtask

    task automatic push_cmd(input cmd_t c);
        drive_cmd(c);
        exp.push_back(c);
        tick_obs();
    endtask

    // Cycle window frames until the FIFO is empty.
    task automatic drain();
        for (int f = 0; f < 20 && level != 0; f++) begin
            vcount = 10'd480;
            ticks_obs(30);
            vcount = 10'd100;
            ticks_obs(3);
        end
    endtask

    task automatic compare_got(input string name);
        check({name, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check({name, "_addr"}, 32'({got[i].tbl, got[i].idx}), 32'({exp[i].tbl, exp[i].idx}));
            check({name, "_data"}, got[i].data, exp[i].data);
        end
    endtask

    // One clock against the reference model: FIFO order, occupancy, ready,
    // window lag, writes only inside an open window, per-frame budget and
    // no unexplained idle cycles while work is pending in an open window.
    task automatic step_model();
        cmd_t c;
        cmd_t e;
        logic push;
        logic win_during;
        int   sz_before;
        c.tbl      = cmd_table;
        c.idx      = cmd_index;
        c.data     = cmd_data;
        push       = cmd_valid && (mq.size() != DEPTH);
        win_during = m_win;
        sz_before  = mq.size();
        tick();
        m_win = in_range(vcount);
        if (m_win && !win_during) m_frame = 0;
        check("rnd_window", 32'(window), 32'(m_win));
        check("rnd_write_eq_cs", 32'(write), 32'(chipselect));
        if (chipselect) begin
            check("rnd_write_allowed", 32'({win_during, sz_before != 0}), 32'(2'b11));
            if (sz_before != 0) begin
                e = mq.pop_front();
                check("rnd_addr", 32'(address), 32'({6'b0, e.tbl, e.idx}));
                check("rnd_data", writedata, e.data);
            end
            m_frame++;
            check("rnd_budget", 32'(m_frame <= EFF_BUDGET), 32'(1));
            m_stall = 0;
        end else if (win_during && sz_before != 0 && m_frame < EFF_BUDGET) begin
            m_stall++;
        end else begin
            m_stall = 0;
        end
        check("rnd_stall", 32'(m_stall <= 2), 32'(1));
        if (push) mq.push_back(c);
        check("rnd_level", 32'(level), 32'(mq.size()));
        check("rnd_ready", 32'(cmd_ready), 32'(mq.size() != DEPTH));
    endtask

    initial begin
        vec_t  vecs[4];
        wvec_t wvecs[7];
        logic [9:0] bnd[4];
        cmd_t c17;
        int   first_t;
        int   last_t;
        int   found;
        int   w1;
        int   w2;
        int   rem;
        int   run_left;
        int   dens;

        vecs[0] = '{tbl: 2'd2, idx: 8'h3F, data: 32'hDEADBEEF, exp_addr: 16'h023F};
        vecs[1] = '{tbl: 2'd0, idx: 8'h00, data: 32'h0000A5A5, exp_addr: 16'h0000};
        vecs[2] = '{tbl: 2'd1, idx: 8'hFF, data: 32'h12345678, exp_addr: 16'h01FF};
        vecs[3] = '{tbl: 2'd3, idx: 8'h80, data: 32'hFFFFFFFF, exp_addr: 16'h0380};

        wvecs[0] = '{v: 10'd479,  exp_win: 1'b0};
        wvecs[1] = '{v: 10'd480,  exp_win: 1'b1};
        wvecs[2] = '{v: 10'd523,  exp_win: 1'b1};
        wvecs[3] = '{v: 10'd524,  exp_win: 1'b0};
        wvecs[4] = '{v: 10'd0,    exp_win: 1'b0};
        wvecs[5] = '{v: 10'd1023, exp_win: 1'b0};
        wvecs[6] = '{v: 10'd500,  exp_win: 1'b1};

        bnd[0] = 10'd479;
        bnd[1] = 10'd480;
        bnd[2] = 10'd523;
        bnd[3] = 10'd524;

        // Reset values.
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_table = 2'd0;
        cmd_index = 8'd0;
        cmd_data  = 32'd0;
        vcount    = 10'd100;
        tick();
        tick();
        check("rst_chipselect", 32'(chipselect), 32'(0));
        check("rst_write", 32'(write), 32'(0));
        check("rst_address", 32'(address), 32'(0));
        check("rst_writedata", writedata, 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_ready", 32'(cmd_ready), 32'(1));
        check("rst_window", 32'(window), 32'(0));
        reset = 1'b0;
        tick();

        // Window decode and one-cycle lag.
        for (int i = 0; i < 7; i++) begin
            vcount = wvecs[i].v;
            tick_obs();
            check("window_table", 32'(window), 32'(wvecs[i].exp_win));
        end

        // Three attr commands queued outside the window, then drained.
        vcount = 10'd100;
        tick();
        tick();
        got.delete();
        exp.delete();
        for (int i = 0; i < 3; i++) begin
            cmd_t c;
            c.tbl  = 2'd0;
            c.idx  = 8'(i);
            c.data = 32'hA0 + 32'(i);
            push_cmd(c);
        end
        cmd_valid = 1'b0;
        check("t1_level_queued", 32'(level), 32'(3));
        ticks_obs(3);
        check("t1_no_bus_outside", 32'(got.size()), 32'(0));
        vcount  = 10'd480;
        first_t = -1;
        last_t  = -1;
        for (int t = 0; t < 12; t++) begin
            tick_obs();
            if (chipselect) begin
                if (first_t < 0) first_t = t;
                last_t = t;
            end
        end
        compare_got("t1");
        check("t1_consecutive", 32'(last_t - first_t), 32'(2));
        check("t1_level_drained", 32'(level), 32'(0));

        // Vector table: address formatting and N+2 issue latency.
        for (int i = 0; i < 4; i++) begin
            cmd_t c;
            vcount = 10'd100;
            tick();
            tick();
            vcount = 10'd480;
            tick();
            tick();
            tick();
            c.tbl  = vecs[i].tbl;
            c.idx  = vecs[i].idx;
            c.data = vecs[i].data;
            drive_cmd(c);
            tick();
            cmd_valid = 1'b0;
            check("vec_n_cs", 32'(chipselect), 32'(0));
            check("vec_n_level", 32'(level), 32'(1));
            tick();
            check("vec_n1_cs", 32'(chipselect), 32'(0));
            tick();
            check("vec_n2_cs", 32'(chipselect), 32'(1));
            check("vec_n2_write", 32'(write), 32'(1));
            check("vec_n2_addr", 32'(address), 32'(vecs[i].exp_addr));
            check("vec_n2_data", writedata, vecs[i].data);
            check("vec_n2_level", 32'(level), 32'(0));
            tick();
            check("vec_n3_cs", 32'(chipselect), 32'(0));
        end

        // Fill to DEPTH outside the window, hold a 17th, then open the window.
        vcount = 10'd100;
        tick();
        tick();
        got.delete();
        exp.delete();
        for (int i = 0; i < DEPTH; i++) push_cmd(rand_cmd());
        check("t2_full_ready", 32'(cmd_ready), 32'(0));
        check("t2_full_level", 32'(level), 32'(DEPTH));
        c17 = rand_cmd();
        drive_cmd(c17);
        ticks_obs(3);
        check("t2_held_level", 32'(level), 32'(DEPTH));
        check("t2_held_ready", 32'(cmd_ready), 32'(0));
        vcount = 10'd480;
        found  = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            tick_obs();
            if (chipselect) found = 1;
        end
        check("t2_first_pop_seen", 32'(found), 32'(1));
        check("t2_ready_after_pop", 32'(cmd_ready), 32'(1));
        check("t2_level_after_pop", 32'(level), 32'(DEPTH - 1));
        tick_obs();
        cmd_valid = 1'b0;
        exp.push_back(c17);
        drain();
        compare_got("t2");
        check("t2_level_end", 32'(level), 32'(0));

        // Window closes after four writes: at most one more, rest next frame.
        vcount = 10'd100;
        tick();
        tick();
        got.delete();
        exp.delete();
        for (int i = 0; i < 10; i++) push_cmd(rand_cmd());
        cmd_valid = 1'b0;
        vcount    = 10'd480;
        for (int t = 0; t < 30 && got.size() < 4; t++) tick_obs();
        check("t3_four_writes", 32'(got.size()), 32'(4));
        vcount = 10'd524;
        ticks_obs(10);
        w1 = got.size();
        check("t3_close_max5", 32'(w1 <= 5), 32'(1));
        check("t3_close_level", 32'(level), 32'(10 - w1));
        vcount = 10'd100;
        ticks_obs(3);
        vcount = 10'd480;
        ticks_obs(30);
        rem = 10 - w1;
        w2  = got.size() - w1;
        check("t3_next_frame", 32'(w2), 32'(rem < EFF_BUDGET ? rem : EFF_BUDGET));
        vcount = 10'd100;
        ticks_obs(3);
        drain();
        compare_got("t3");
        check("t3_level_end", 32'(level), 32'(0));

        // Six queued commands against the per-frame budget.
        vcount = 10'd100;
        tick();
        tick();
        got.delete();
        exp.delete();
        for (int i = 0; i < 6; i++) push_cmd(rand_cmd());
        cmd_valid = 1'b0;
        vcount    = 10'd480;
        ticks_obs(20);
        w1 = got.size();
        check("t4_first_frame", 32'(w1), 32'(6 < EFF_BUDGET ? 6 : EFF_BUDGET));
        vcount = 10'd100;
        ticks_obs(3);
        vcount = 10'd480;
        ticks_obs(20);
        check("t4_second_frame", 32'(got.size() - w1), 32'(6 - (6 < EFF_BUDGET ? 6 : EFF_BUDGET)));
        check("t4_level_end", 32'(level), 32'(0));
        vcount = 10'd100;
        ticks_obs(3);
        compare_got("t4");

        // Reset in the middle of a burst discards everything pending.
        got.delete();
        exp.delete();
        for (int i = 0; i < 8; i++) push_cmd(rand_cmd());
        cmd_valid = 1'b0;
        vcount    = 10'd480;
        found     = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            tick_obs();
            if (chipselect) found = 1;
        end
        check("t5_burst_started", 32'(found), 32'(1));
        tick_obs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_cs_after_reset", 32'(chipselect), 32'(0));
        check("t5_level_after_reset", 32'(level), 32'(0));
        check("t5_ready_after_reset", 32'(cmd_ready), 32'(1));
        got.delete();
        ticks_obs(20);
        vcount = 10'd100;
        ticks_obs(3);
        vcount = 10'd480;
        ticks_obs(20);
        check("t5_no_writes_after_reset", 32'(got.size()), 32'(0));

        // Randomized traffic against the reference model.
        vcount = 10'd100;
        tick();
        tick();
        tick();
        mq.delete();
        m_win    = 1'b0;
        m_frame  = 0;
        m_stall  = 0;
        run_left = 0;
        dens     = 5;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (run_left == 0) begin
                run_left = $urandom_range(1, 25);
                dens     = $urandom_range(2, 10);
                case ($urandom_range(0, 3))
                    0:       vcount = 10'($urandom_range(480, 523));
                    1:       vcount = 10'($urandom_range(0, 479));
                    2:       vcount = 10'($urandom_range(524, 1023));
                    default: vcount = bnd[$urandom_range(0, 3)];
                endcase
            end
            run_left--;
            drive_cmd(rand_cmd());
            cmd_valid = ($urandom_range(0, 9) < dens);
            step_model();
        end
        cmd_valid = 1'b0;
        for (int f = 0; f < 40 && mq.size() != 0; f++) begin
            vcount = 10'd480;
            for (int i = 0; i < 30; i++) step_model();
            vcount = 10'd100;
            for (int i = 0; i < 3; i++) step_model();
        end
        check("rnd_drained", 32'(mq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
